bit_assembler: RTL and testbench
================================

// Module: bit_assembler
// PURPOSE
//   Receive end of the LSB-first serial bit stream shifted out by the team's
//   shift-and-count datapath. Collects WIDTH serial bits into a parallel word.
//   Counts the ones incrementally as the bits arrive.
//   Presents word, ones count and zero flag to downstream logic via a valid/ready handshake.
// PARAMETERS
//   WIDTH  4  bits per frame, >= 2
//   CW     3  width of ones count; must satisfy 2**CW > WIDTH
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      reset, asynchronous, active-low
//   start      in   1      begin a new frame (clears shift reg, count and index)
//   sin        in   1      serial data bit, LSB of frame first
//   sin_valid  in   1      sin is sampled on this clock edge
//   out_ready  in   1      downstream accepts the presented result
//   busy       out  1      1 while in SHIFT
//   done       out  1      result valid (1 while in DONE)
//   word       out  WIDTH  assembled word, held stable while done=1
//   ones       out  CW     number of 1 bits in word
//   z          out  1      ~|word, combinational from the word register
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; shift reg, idx, running count, word and ones=0.
//     Outputs on reset: busy=0, done=0, z=1.
//   Reset mid-frame discards the partial frame. No result is produced.
//   FSM states: IDLE, SHIFT, DONE. busy and done are decoded from state (registered).
//   IDLE:
//     start=1 -> clear sreg, idx and cnt; next state SHIFT. sin_valid is ignored.
//   SHIFT, edge with sin_valid=1:
//     sreg <= {sin, sreg[WIDTH-1:1]}; cnt <= cnt + sin; idx <= idx + 1.
//   SHIFT, accepting the last bit (sin_valid=1 and idx==WIDTH-1):
//     word <= {sin, sreg[WIDTH-1:1]}; ones <= cnt + sin; next state DONE.
//     done=1 on the cycle after the WIDTH-th accepted bit (latency 1).
//   SHIFT with sin_valid=0: hold. Gaps of any length are allowed.
//   SHIFT with start=1: abort and restart the frame.
//     Clear sreg, idx and cnt; stay SHIFT; sin is not sampled that edge.
//     start has priority over sin_valid.
//   DONE:
//     word and ones hold until accepted. sin_valid is ignored.
//     out_ready=1 -> IDLE; done drops on the next cycle.
//     out_ready=1 and start=1 -> go directly to SHIFT with cleared sreg, idx and cnt.
//     start=1 with out_ready=0 -> ignored; stay DONE.
//   Arithmetic:
//     cnt and ones are CW bits wide and never wrap, because the maximum is WIDTH < 2**CW.
//     idx is clog2(WIDTH) bits and is cleared on frame start, never by wrap.
//   word and ones keep the last accepted frame in IDLE. They change only on a frame completion.
//   First bit received lands in word[0]. The last bit received lands in word[WIDTH-1].
// TESTING
//   1 Reset: rst=0 mid-SHIFT after 2 bits -> busy=0, done=0, word=0, ones=0, z=1 immediately.
//     After release, idle until start.
//   2 Basic frame (WIDTH=4): start, then sin=1,0,1,1 on consecutive valid edges.
//     -> done=1 one cycle later; word=4'b1101; ones=3; z=0.
//   3 Gapped input: same bits with sin_valid low for 3 cycles between each.
//     -> same word/ones. busy=1 throughout; done only after the 4th valid bit.
//   4 Backpressure: hold out_ready=0 for 5 cycles in DONE while sin toggles and start pulses.
//     -> word/ones unchanged; out_ready=1 -> done=0 the next cycle.
//   5 Back-to-back: in DONE, start=1 with out_ready=1, then frame 0,0,0,0.
//     -> busy the next cycle; result word=0, ones=0, z=1.
//   6 Abort: start, 2 bits of 1, start again, then 1,1,1,1.
//     -> word=4'b1111, ones=4; no stale bits.

Source files
------------

// File: rtl/bit_assembler.sv
// Serial-to-parallel receiver for an LSB-first bit stream. It also keeps a running ones count.
// The finished word, its ones count and a zero flag are offered downstream with valid/ready.
module bit_assembler #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    ones,
  output logic             z,
  output logic [1:0]       state_dbg
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;

  // Handshake: done is valid; a result transfers on any edge where done && out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
      cnt   <= '0;
      word  <= '0;
      ones  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg  <= '0;
            idx   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            sreg <= '0;
            idx  <= '0;
            cnt  <= '0;
          end else if (sin_valid) begin
            sreg <= {sin, sreg[WIDTH-1:1]};
            cnt  <= cnt + CW'(sin);
            idx  <= idx + IW'(1);
            if (idx == IW'(WIDTH - 1)) begin
              word  <= {sin, sreg[WIDTH-1:1]};
              ones  <= cnt + CW'(sin);
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            if (start) begin
              sreg  <= '0;
              idx   <= '0;
              cnt   <= '0;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign z         = ~|word;
  assign state_dbg = state;

endmodule

// File: tb/tb_bit_assembler.sv
// Bench for bit_assembler (WIDTH=4, CW=3): hand tables, directed corner sequences and random traffic.
// Every cycle is checked against a queue-based frame model.
module tb_bit_assembler;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0;
  logic             busy, done, z;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    ones;
  logic [1:0]       state_dbg;

  bit_assembler #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .word(word), .ones(ones),
    .z(z), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 result held.
  int               m_phase = 0;
  logic             m_bits[$];
  logic [WIDTH-1:0] m_word = '0;
  logic [CW-1:0]    m_ones = '0;
  logic             m_comp = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_bits.delete();
    m_word  = '0;
    m_ones  = '0;
    m_comp  = 1'b0;
  endtask

  task automatic model_update(input logic st, input logic s, input logic sv, input logic ordy);
    logic [WIDTH-1:0] w;
    m_comp = 1'b0;
    case (m_phase)
      0: if (st) begin m_bits.delete(); m_phase = 1; end
      1: begin
        if (st) m_bits.delete();
        else if (sv) begin
          m_bits.push_back(s);
          if (m_bits.size() == WIDTH) begin
            w = '0;
            for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
            m_word  = w;
            m_ones  = CW'($countones(w));
            m_bits.delete();
            m_phase = 2;
            m_comp  = 1'b1;
            exp_q.push_back(w);
          end
        end
      end
      default: if (ordy) m_phase = st ? 1 : 0;
    endcase
  endtask

  task automatic model_check();
    logic [WIDTH-1:0] e;
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("word", 32'(word), 32'(m_word));
    chk("ones", 32'(ones), 32'(m_ones));
    chk("z", 32'(z), 32'(m_word == '0));
    if (m_comp) begin
      e = exp_q.pop_front();
      chk("sb_word", 32'(word), 32'(e));
    end
  endtask

  task automatic step(input logic st, input logic s, input logic sv, input logic ordy);
    start = st; sin = s; sin_valid = sv; out_ready = ordy;
    @(posedge clk);
    model_update(st, s, sv, ordy);
    #1;
    model_check();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] bits, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, bits[i], 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  typedef struct {
    logic             st, s, sv, ordy;
    logic             e_busy, e_done;
    logic [WIDTH-1:0] e_word;
    logic [CW-1:0]    e_ones;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 3'd3};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 3'd3};

    // Reset held from time 0; released away from a clock edge.
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", 32'(z), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Basic frame 1,0,1,1 from the table.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].st, tbl[i].s, tbl[i].sv, tbl[i].ordy);
      chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
      chk("tbl_word", 32'(word), 32'(tbl[i].e_word));
      chk("tbl_ones", 32'(ones), 32'(tbl[i].e_ones));
      chk("tbl_z", 32'(z), 32'(tbl[i].e_word == '0));
    end

    // Asynchronous reset mid-frame after two bits.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_word", 32'(word), 32'd0);
    chk("mid_rst_ones", 32'(ones), 32'd0);
    chk("mid_rst_z", 32'(z), 32'd1);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Gapped input: three invalid cycles between bits.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1101, 3);
    chk("gap_word", 32'(word), 32'hD);
    chk("gap_ones", 32'(ones), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result must hold while sin toggles and start pulses.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'(i % 2), 1'(i % 2), 1'b1, 1'b0);
      chk("bp_word", 32'(word), 32'h6);
      chk("bp_ones", 32'(ones), 32'd2);
      chk("bp_done", 32'(done), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_release", 32'(done), 32'd0);

    // Back-to-back: accept with start, then an all-zero frame.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1011, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    send_frame(4'b0000, 0);
    chk("b2b_word", 32'(word), 32'd0);
    chk("b2b_ones", 32'(ones), 32'd0);
    chk("b2b_z", 32'(z), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort: restart after two ones, start has priority over a valid bit.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(4'b1111, 0);
    chk("abort_word", 32'(word), 32'hF);
    chk("abort_ones", 32'(ones), 32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
